mult_share_scheduler: RTL
=========================

// Module: mult_share_scheduler
// PURPOSE
//  Shares one cyclic_multiplier between N requesters.
//  - Round-robin arbitration over valid/ready request ports.
//  - Captures the winner's operands and pulses the multiplier load for one cycle.
//  - Waits for the multiplier's valid flag, then returns the product tagged with the requester id.
//  - Sits between the client blocks and a single cyclic_multiplier instance.
// PARAMETERS
//  N    4           number of requesters (>=2)
//  W    4           operand width; must match the multiplier's W
//  IDW  $clog2(N)   requester id width (derived; do not override)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  req_valid   in   N      bit i: requester i has operands pending
//  req_a       in   N*W    requester i operand a at [i*W +: W]
//  req_b       in   N*W    requester i operand b at [i*W +: W]
//  req_ready   out  N      one-hot grant; transfer on req_valid[i]&req_ready[i]
//  mult_load   out  1      load pulse to the multiplier
//  mult_a      out  W      operand a to the multiplier
//  mult_b      out  W      operand b to the multiplier
//  mult_p      in   2*W    multiplier product
//  mult_valid  in   1      multiplier valid (high when the multiplier is idle)
//  rsp_valid   out  1      result available
//  rsp_id      out  IDW    index of the requester that owns the result
//  rsp_p       out  2*W    product
//  rsp_ready   in   1      consumer accepts; transfer on rsp_valid&rsp_ready
// BEHAVIOUR
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE
//    - req_ready is one-hot: the first set req_valid bit at or after rr_ptr, searching upward with wrap.
//    - On a transfer: latch id, a and b; go to ISSUE.
//    - With no request: req_ready=0 and the FSM stays in IDLE.
//  - ISSUE: mult_load=1 for exactly one cycle with the latched operands; go to WAIT.
//  - WAIT
//    - mult_valid is low from the cycle after the load edge.
//    - On the first cycle mult_valid=1: latch mult_p into rsp_p; go to RESP.
//  - RESP
//    - rsp_valid=1 and rsp_p/rsp_id are held stable until rsp_ready.
//    - On the transfer: rr_ptr <= (id+1) mod N; go to IDLE.
//  - req_ready and mult_load are 0 in every state other than the one named above.
//  - mult_a/mult_b always show the latched operand registers.
//  Latency
//  - Request accepted in cycle 0, ISSUE in cycle 1, multiplier valid in cycle W+2.
//  - rsp_valid is first high in cycle W+3 (W=4: cycle 7).
//  - Back-to-back throughput is one product per W+4 cycles when rsp_ready is held high.
//  Widths
//  - Product width is exactly 2*W with no truncation.
//  - rr_ptr is IDW bits; when N is not a power of 2, the wrap is explicit at N-1 -> 0.
//  Boundary conditions
//  - Only one request is in flight. The scheduler has no internal queue.
//  - A req_valid that drops without a transfer is simply not granted. No state changes.
//  - If all N requesters are valid, each is served once before any is served twice (fairness).
//  - A new request that is high while the FSM is in RESP is not granted until IDLE.
//  - rsp_ready in any state other than RESP is ignored.
//  - Reset mid-operation
//    - All registers clear asynchronously: state=IDLE, rr_ptr=0, operands=0, rsp_p=0, rsp_id=0.
//    - The multiplier has no reset. The next ISSUE load restarts it, so a stale calculation has no effect.
//  - Reset values: req_ready=0, mult_load=0, mult_a=0, mult_b=0, rsp_valid=0, rsp_id=0, rsp_p=0.
// CONFIGURATION
//  MULT_SHARE_PERF_EN
//  - Defined: adds outputs perf_busy[31:0] and perf_done[15:0].
//    - perf_busy increments on every cycle the state is not IDLE.
//    - perf_done increments on every response transfer.
//    - Both saturate at all-ones and clear on rst_n.
//  - Undefined: these ports and their counters do not exist.
//  - Core behaviour and latency are identical either way.
// TESTING
//  1. Single op: requester 2 sends a=9, b=7 (W=4), rsp_ready=1.
//     -> rsp_valid in cycle 7, rsp_id=2, rsp_p=63.
//  2. All four requesters valid together, each with a=15, b=15.
//     -> grants in order 0,1,2,3; each rsp_p=225; gap between grants is 8 cycles.
//  3. Response backpressure: rsp_ready low for 5 cycles after rsp_valid.
//     -> rsp_p/rsp_id stable; no req_ready while held.
//  4. Wrap: requesters 3 and 0 valid, rr_ptr=3.
//     -> 3 is granted, then 0; rr_ptr returns to 1.
//  5. Reset asserted during WAIT.
//     -> all outputs 0 at once. After release, the next request (a=5, b=3) gives rsp_p=15 at the normal latency.
//  6. Zero operands: a=0, b=13.
//     -> rsp_p=0. With the perf macro defined, perf_done=1 and perf_busy=W+3 after the transfer.

Source files
------------

// File: rtl/mult_share_scheduler.sv
// Round-robin front end that time-shares one cyclic_multiplier between N requesters.
// Optional MULT_SHARE_PERF_EN adds saturating busy-cycle and completed-response counters.
module mult_share_scheduler #(
    parameter  int N   = 4,
    parameter  int W   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic           mult_load,
    output logic [W-1:0]   mult_a,
    output logic [W-1:0]   mult_b,
    input  logic [2*W-1:0] mult_p,
    input  logic           mult_valid,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [2*W-1:0] rsp_p,
    input  logic           rsp_ready
`ifdef MULT_SHARE_PERF_EN
    ,
    output logic [31:0]    perf_busy,
    output logic [15:0]    perf_done
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_d;
    logic [IDW-1:0] rr_ptr, id_q, gnt_id;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] p_q;
    logic [N-1:0]   gnt;
    logic           found;
    int             idx;

    // First valid requester at or after rr_ptr, wrapping explicitly at N-1.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = '0;
        mult_load = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                mult_load = 1'b1;
                state_d   = WAIT;
            end
            WAIT: if (mult_valid) state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && found) begin
                id_q <= gnt_id;
                a_q  <= req_a[int'(gnt_id)*W +: W];
                b_q  <= req_b[int'(gnt_id)*W +: W];
            end
            if (state == WAIT && mult_valid) p_q <= mult_p;
            if (state == RESP && rsp_ready)
                rr_ptr <= (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
        end
    end

    assign mult_a = a_q;
    assign mult_b = b_q;
    assign rsp_id = id_q;
    assign rsp_p  = p_q;

`ifdef MULT_SHARE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy <= '0;
            perf_done <= '0;
        end else begin
            if (state != IDLE && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
            if (rsp_valid && rsp_ready && perf_done != '1) perf_done <= perf_done + 1'b1;
        end
    end
`endif

endmodule
